// File: rtl/comp_seq.sv
// Digit-serial unsigned magnitude comparator: compares A and B one D-bit digit
// per clock from MSB to LSB. Optional macro COMP_SEQ_EARLY_EXIT_EN ends the scan at the first differing digit.
module comp_seq #(
    parameter int W = 8,
    parameter int D = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic         aeb,
    output logic         agb,
    output logic         alb
);

    localparam int N  = W / D;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] REL_EQ = 2'd0;
    localparam logic [1:0] REL_GT = 2'd1;
    localparam logic [1:0] REL_LT = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_r, state_next_s;
    logic [IW-1:0] idx_r, idx_next_s;
    logic [1:0]    rel_r, rel_next_s;
    logic [W-1:0]  a_r, a_next_s;
    logic [W-1:0]  b_r, b_next_s;
    logic [D-1:0]  a_dig_s, b_dig_s;
    logic          exit_s;
    logic          busy_r, done_r, aeb_r, agb_r, alb_r;

    function automatic logic [1:0] digit_rel(input logic [D-1:0] x, input logic [D-1:0] y);
        if (x > y) begin
            digit_rel = REL_GT;
        end else if (x < y) begin
            digit_rel = REL_LT;
        end else begin
            digit_rel = REL_EQ;
        end
    endfunction

    // Next-state, operand capture and running-relation update
    always_comb begin
        state_next_s = state_r;
        idx_next_s   = idx_r;
        rel_next_s   = rel_r;
        a_next_s     = a_r;
        b_next_s     = b_r;
        a_dig_s      = a_r[int'(idx_r)*D +: D];
        b_dig_s      = b_r[int'(idx_r)*D +: D];
        exit_s       = 1'b0;
        case (state_r)
            S_IDLE, S_DONE: begin
                if (start) begin
                    a_next_s     = a;
                    b_next_s     = b;
                    idx_next_s   = IW'(N - 1);
                    rel_next_s   = REL_EQ;
                    state_next_s = S_RUN;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_RUN: begin
                // A decided relation is sticky; only an equal prefix looks at the digit.
                if (rel_r == REL_EQ) begin
                    rel_next_s = digit_rel(a_dig_s, b_dig_s);
                end else begin
                    rel_next_s = rel_r;
                end
                idx_next_s = idx_r - IW'(1);
`ifdef COMP_SEQ_EARLY_EXIT_EN
                exit_s = (idx_r == IW'(0)) || (rel_next_s != REL_EQ);
`else
                exit_s = (idx_r == IW'(0));
`endif
                if (exit_s) begin
                    state_next_s = S_DONE;
                end else begin
                    state_next_s = S_RUN;
                end
            end
            default: begin
                state_next_s = S_IDLE;
            end
        endcase
    end

    // State, datapath and registered status/result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
            idx_r   <= '0;
            rel_r   <= REL_EQ;
            a_r     <= '0;
            b_r     <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            aeb_r   <= 1'b0;
            agb_r   <= 1'b0;
            alb_r   <= 1'b0;
        end else begin
            state_r <= state_next_s;
            idx_r   <= idx_next_s;
            rel_r   <= rel_next_s;
            a_r     <= a_next_s;
            b_r     <= b_next_s;
            busy_r  <= (state_next_s == S_RUN);
            done_r  <= (state_next_s == S_DONE);
            if ((state_r == S_RUN) && (state_next_s == S_DONE)) begin
                aeb_r <= (rel_next_s == REL_EQ);
                agb_r <= (rel_next_s == REL_GT);
                alb_r <= (rel_next_s == REL_LT);
            end else begin
                aeb_r <= aeb_r;
                agb_r <= agb_r;
                alb_r <= alb_r;
            end
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign aeb  = aeb_r;
    assign agb  = agb_r;
    assign alb  = alb_r;

endmodule

// File: tb/tb_comp_seq.sv
// Directed bench for comp_seq: vector table on W=8/D=2, hand sequences for
// busy-ignore, back-to-back, reset abort, plus W=4/D=1 exhaustive and W=4/D=4.
module tb_comp_seq;

`ifdef COMP_SEQ_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start;
    logic [7:0] a, b;
    logic       busy, done, aeb, agb, alb;

    logic       s4_start;
    logic [3:0] s4_a, s4_b;
    logic       s4_busy, s4_done, s4_aeb, s4_agb, s4_alb;

    logic       n1_start;
    logic [3:0] n1_a, n1_b;
    logic       n1_busy, n1_done, n1_aeb, n1_agb, n1_alb;

    comp_seq #(.W(8), .D(2)) u_dut8 (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .aeb(aeb), .agb(agb), .alb(alb)
    );

    comp_seq #(.W(4), .D(1)) u_dut4 (
        .clk(clk), .rst(rst), .start(s4_start), .a(s4_a), .b(s4_b),
        .busy(s4_busy), .done(s4_done), .aeb(s4_aeb), .agb(s4_agb), .alb(s4_alb)
    );

    comp_seq #(.W(4), .D(4)) u_dut1 (
        .clk(clk), .rst(rst), .start(n1_start), .a(n1_a), .b(n1_b),
        .busy(n1_busy), .done(n1_done), .aeb(n1_aeb), .agb(n1_agb), .alb(n1_alb)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [7:0] va;
        logic [7:0] vb;
        logic [2:0] res;       // {aeb, agb, alb}
        int         lat_full;
        int         lat_early;
    } vec_t;

    vec_t       vecs[10];
    logic [2:0] last_res;

    // Launch one W=8 comparison, scramble inputs after capture, then time the result.
    task automatic run8(input logic [7:0] va, input logic [7:0] vb,
                        input logic [2:0] exp_res, input int exp_lat);
        int cyc;
        bit got;
        @(negedge clk);
        a = va; b = vb; start = 1'b1;
        @(posedge clk); #1;
        check("busy_after_start", int'(busy), 1);
        check("no_done_at_start", int'(done), 0);
        start = 1'b0; a = ~va; b = ~vb;
        cyc = 0; got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk); #1;
            cyc++;
            if (done) got = 1'b1;
            else check("held_in_run", int'({aeb, agb, alb}), int'(last_res));
        end
        check("done_seen", int'(got), 1);
        check("latency", cyc, exp_lat);
        check("result", int'({aeb, agb, alb}), int'(exp_res));
        check("busy_at_done", int'(busy), 0);
        last_res = exp_res;
        @(posedge clk); #1;
        check("done_one_cycle", int'(done), 0);
        check("result_held", int'({aeb, agb, alb}), int'(exp_res));
    endtask

    initial begin
        int cyc, pulses, lat;
        bit got;
        logic [2:0] er;

        vecs[0] = '{8'h00, 8'h00, 3'b100, 4, 4};
        vecs[1] = '{8'hC0, 8'h00, 3'b010, 4, 1};
        vecs[2] = '{8'h12, 8'h13, 3'b001, 4, 4};
        vecs[3] = '{8'hFF, 8'h00, 3'b010, 4, 1};
        vecs[4] = '{8'h00, 8'hFF, 3'b001, 4, 1};
        vecs[5] = '{8'hA5, 8'hA5, 3'b100, 4, 4};
        vecs[6] = '{8'h34, 8'h38, 3'b001, 4, 3};
        vecs[7] = '{8'h81, 8'h80, 3'b010, 4, 4};
        vecs[8] = '{8'h4C, 8'h48, 3'b010, 4, 3};
        vecs[9] = '{8'h20, 8'h10, 3'b010, 4, 2};

        rst = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00;
        s4_start = 1'b0; s4_a = 4'h0; s4_b = 4'h0;
        n1_start = 1'b0; n1_a = 4'h0; n1_b = 4'h0;
        last_res = 3'b000;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_results", int'({aeb, agb, alb}), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run8(vecs[i].va, vecs[i].vb, vecs[i].res,
                 EARLY ? vecs[i].lat_early : vecs[i].lat_full);
        end

        // start held high while busy with a changed operand: must be ignored
        @(negedge clk);
        a = 8'hFF; b = 8'h00; start = 1'b1;
        @(posedge clk); #1;
        a = 8'h00;
        cyc = 0; got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk); #1;
            cyc++;
            if (done) begin
                got = 1'b1;
                start = 1'b0;
            end
        end
        check("ign_done_seen", int'(got), 1);
        check("ign_latency", cyc, EARLY ? 1 : 4);
        check("ign_result", int'({aeb, agb, alb}), 3'b010);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        check("ign_single_done", pulses, 0);
        check("ign_idle_busy", int'(busy), 0);
        last_res = 3'b010;

        // back-to-back: start asserted during DONE restarts immediately
        @(negedge clk);
        a = 8'h12; b = 8'h13; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk); #1;
            if (done) got = 1'b1;
        end
        check("b2b_first_done", int'(got), 1);
        check("b2b_first_res", int'({aeb, agb, alb}), 3'b001);
        a = 8'h20; b = 8'h10; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b_restart_busy", int'(busy), 1);
        check("b2b_restart_done", int'(done), 0);
        check("b2b_restart_held", int'({aeb, agb, alb}), 3'b001);
        cyc = 0; got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk); #1;
            cyc++;
            if (done) got = 1'b1;
        end
        check("b2b_second_latency", cyc, EARLY ? 2 : 4);
        check("b2b_second_res", int'({aeb, agb, alb}), 3'b010);
        last_res = 3'b010;

        // reset two cycles after start aborts without a done pulse
        @(negedge clk);
        a = 8'h12; b = 8'h13; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_results", int'({aeb, agb, alb}), 0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (done || busy) pulses++;
        end
        check("abort_no_activity", pulses, 0);
        last_res = 3'b000;
        run8(8'hC0, 8'h00, 3'b010, EARLY ? 1 : 4);

        // W=4, D=1 exhaustive against an unsigned reference compare
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                er = (ia == ib) ? 3'b100 : ((ia > ib) ? 3'b010 : 3'b001);
                lat = 4;
                if (EARLY) begin
                    for (int bt = 3; bt >= 0; bt--) begin
                        if (((ia >> bt) & 1) != ((ib >> bt) & 1)) begin
                            lat = 4 - bt;
                            break;
                        end
                    end
                end
                @(negedge clk);
                s4_a = 4'(ia); s4_b = 4'(ib); s4_start = 1'b1;
                @(posedge clk); #1;
                s4_start = 1'b0;
                cyc = 0; got = 1'b0;
                for (int i = 0; i < 10 && !got; i++) begin
                    @(posedge clk); #1;
                    cyc++;
                    if (s4_done) got = 1'b1;
                end
                check("w4_result", int'({s4_aeb, s4_agb, s4_alb}), int'(er));
                check("w4_latency", cyc, lat);
            end
        end

        // D = W: single digit, done one cycle after start
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            case (i)
                0:       begin n1_a = 4'h9; n1_b = 4'h3; er = 3'b010; end
                1:       begin n1_a = 4'h5; n1_b = 4'h5; er = 3'b100; end
                default: begin n1_a = 4'h2; n1_b = 4'h7; er = 3'b001; end
            endcase
            n1_start = 1'b1;
            @(posedge clk); #1;
            n1_start = 1'b0;
            check("n1_busy", int'(n1_busy), 1);
            @(posedge clk); #1;
            check("n1_done", int'(n1_done), 1);
            check("n1_result", int'({n1_aeb, n1_agb, n1_alb}), int'(er));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/comp_seq.md
COMP_SEQ -- requirements
Module: comp_seq

Interface
REQ-001 Parameter W, default 8, operand width in bits; SHALL be a positive multiple of D.
REQ-002 Parameter D, default 2, digit width compared per clock; N = W/D digits.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge only.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request a comparison; accepted only when busy=0.
REQ-006 a  input  W  operand A, unsigned; sampled only on an accepted start.
REQ-007 b  input  W  operand B, unsigned; sampled only on an accepted start.
REQ-008 busy  output  1  high while a comparison is in progress.
REQ-009 done  output  1  one-cycle pulse marking result valid.
REQ-010 aeb  output  1  result A == B.
REQ-011 agb  output  1  result A > B.
REQ-012 alb  output  1  result A < B.

Function
REQ-013 FSM states SHALL be IDLE, RUN and DONE.
REQ-014 IDLE or DONE with start=1: capture a and b, set digit index to N-1 (MSB digit), clear running relation to "equal", go to RUN.
REQ-015 RUN: each cycle SHALL compare digit[idx] of the captured A and B, then decrement idx.
REQ-016 Running relation: once a digit differs, relation becomes "greater" or "less" and SHALL NOT change for the rest of the comparison.
REQ-017 RUN -> DONE after the idx=0 digit is processed, giving N RUN cycles.
REQ-018 Latency: start sampled at edge k -> busy=1 from edge k through edge k+N-1; done=1 and busy=0 after edge k+N.
REQ-019 Entering DONE, aeb/agb/alb SHALL update to the final relation, exactly one-hot.
REQ-020 DONE lasts one cycle; done SHALL deassert afterwards (or at once re-enter RUN if start=1).
REQ-021 Result outputs SHALL hold their value until the next comparison completes; they SHALL NOT change during RUN.
REQ-022 start while busy=1 SHALL be ignored, with no effect on state or captured operands.
REQ-023 Changes on a and b after capture SHALL NOT affect the result in progress.
REQ-024 D = W (N=1) SHALL be legal: done is asserted one cycle after start.

Reset
REQ-025 rst=1 SHALL force IDLE with busy=0, done=0, aeb=0, agb=0 and alb=0, clearing the index and captured operands.
REQ-026 rst SHALL take priority over start and abort any comparison in progress; no done pulse is produced for the aborted comparison.
REQ-027 After reset, all result outputs read 0 until the first comparison completes.

Configuration
REQ-028 Macro COMP_SEQ_EARLY_EXIT_EN SHALL be the only compile-time option.
REQ-029 With COMP_SEQ_EARLY_EXIT_EN defined, RUN SHALL go to DONE in the same cycle the first differing digit is found; latency is (N - idx_of_first_difference) cycles.
REQ-030 With COMP_SEQ_EARLY_EXIT_EN defined, operands that differ in no digit SHALL still take N cycles.
REQ-031 Without COMP_SEQ_EARLY_EXIT_EN, latency SHALL be exactly N cycles for all operand values.
REQ-032 Result values SHALL be identical with and without the macro.

Verification (W=8, D=2 unless stated)
REQ-033 a=0x00, b=0x00, start pulse -> done 4 cycles later, aeb=1, agb=0, alb=0.
REQ-034 a=0xC0, b=0x00 -> agb=1; done after 1 cycle with COMP_SEQ_EARLY_EXIT_EN, after 4 cycles without.
REQ-035 a=0x12, b=0x13 -> alb=1 after 4 cycles in both builds; results held until the next done.
REQ-036 start with a=0xFF, b=0x00, then start=1 and a=0x00 each cycle while busy -> the second request is ignored; one done pulse with agb=1.
REQ-037 rst=1 two cycles after start -> busy=0, all outputs 0, no done pulse; a new start then completes normally.
REQ-038 W=4, D=1: exhaustive 256 operand pairs -> each result matches an unsigned reference compare; done after 4 cycles when early exit is disabled.
